adc_serial_writer: RTL
======================

// Module: adc_serial_writer
//
// PURPOSE
//  Parallel-to-serial word transmitter. It is the writer end of the serial ADC link.
//  It accepts a DATLEN-bit word over a valid/ready handshake and frames it with cs_n
//  and a divided serial clock (sclk). It shifts the word out MSB first on sdo, with
//  an optional leading 0 bit. Used to drive serial DACs, and as a bench/loopback
//  source for the ADC receive path, which samples sdo on the falling edge of sclk.
//
// PARAMETERS
//  DATLEN    12  data word width in bits; legal range >= 2
//  CLKDIV     2  clk cycles per sclk half-period; legal range >= 1
//  LEAD_ZERO  1  1: send one 0 bit before the MSB (the receiver skips it); 0: no lead bit
//
// PORTS
//  clk    in   1       system clock; all logic is on its rising edge
//  rst_n  in   1       asynchronous reset, active low
//  data   in   DATLEN  word to send; sampled only on accept
//  valid  in   1       data is valid
//  ready  out  1       block is idle and can accept a word
//  sclk   out  1       serial clock; idles low
//  cs_n   out  1       frame select, active low
//  sdo    out  1       serial data, MSB first
//  done   out  1       one-clk pulse after the last bit of a frame
//
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, ready=1, cs_n=1, sclk=0, sdo=0,
//    done=0, shift register and counters cleared. Reset asserted mid-frame aborts the
//    frame at once. No done pulse is produced for an aborted frame.
//  - Accept: valid && ready at a clk edge. data is latched into the shift register and
//    ready drops on that same edge. data and valid are don't-care while ready=0.
//  - FSM: IDLE -> SHIFT (on accept) -> GAP (after the last bit) -> IDLE.
//  - Frame length NB = DATLEN + LEAD_ZERO (+1 with parity, see CONFIGURATION).
//    Bit counter width is $clog2(NB+1); divider counter width is $clog2(CLKDIV).
//  - SHIFT state:
//      cs_n=0 from the accept edge.
//      Each bit period lasts 2*CLKDIV clks: sclk is high for the first CLKDIV clks and
//      low for the last CLKDIV clks.
//      sdo updates only at the start of a bit period (the edge where sclk rises), so
//      it is stable across the falling edge.
//      The first bit period starts on the accept edge.
//      Bit order: lead 0 (if LEAD_ZERO), then data[DATLEN-1] down to data[0].
//  - End of the last bit period (exactly NB*2*CLKDIV clks after accept): cs_n=1,
//    sclk=0, sdo=0, done=1 for one clk, state becomes GAP.
//  - GAP: cs_n stays high for 2*CLKDIV clks, then IDLE with ready=1.
//    If valid is held high, the next accept occurs on the first IDLE edge.
//    Minimum accept-to-accept distance: (NB+1)*2*CLKDIV clks.
//  - sclk, cs_n, sdo and done are driven straight from flops (glitch-free).
//
// CONFIGURATION
//  ADC_WRITER_PARITY_EN defined: one extra bit is appended after data[0]. It is the
//    XOR of all DATLEN data bits (even parity over the data). NB grows by 1, and all
//    timing above scales with the new NB.
//  ADC_WRITER_PARITY_EN undefined: no parity bit; NB = DATLEN + LEAD_ZERO.
//
// TESTING (DATLEN=12, CLKDIV=2, LEAD_ZERO=1 unless stated)
//  1 Send 12'hA5C -> cs_n low for 52 clks. Sampling sdo at each sclk fall gives
//    0,1010_0101_1100. One done pulse at clk 52. ready=1 again at clk 56.
//  2 Hold valid high with words 12'h001 then 12'hFFF -> second accept exactly 56 clks
//    after the first. Both words are recovered intact. Changing data mid-frame has no
//    effect on the frame in flight.
//  3 Assert rst_n=0 at clk 20 of a frame -> cs_n=1, sclk=0, sdo=0 and ready=1
//    immediately, with no done pulse. The next word is sent correctly.
//  4 CLKDIV=1, LEAD_ZERO=0, word 12'h800 -> sclk toggles every clk. Serial stream is
//    1 followed by 11 zeros. cs_n low for 24 clks.
//  5 ADC_WRITER_PARITY_EN defined -> 12'hA5C appends parity 0; 12'h001 appends
//    parity 1. cs_n low for 56 clks.
//  6 Loopback into the ADC receive model (skip 1 bit, 12-bit words), 100 random words
//    -> every word is recovered in order. rdy count equals done count.

Source files
------------

// File: rtl/adc_serial_writer.sv
`default_nettype none
// ============================================================================
// Module   : adc_serial_writer
// Purpose  : Parallel-to-serial word transmitter framed by cs_n and a divided
//            sclk; shifts MSB first on sdo with an optional leading 0 bit.
//            Optional parity bit: define ADC_WRITER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adc_serial_writer #(
  parameter int DATLEN    = 12,
  parameter int CLKDIV    = 2,
  parameter int LEAD_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATLEN-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              sclk,
  output logic              cs_n,
  output logic              sdo,
  output logic              done
);

`ifdef ADC_WRITER_PARITY_EN
  localparam int c_PAR_BITS = 1;
`else
  localparam int c_PAR_BITS = 0;
`endif
  localparam int c_NB   = DATLEN + LEAD_ZERO + c_PAR_BITS;
  localparam int c_BCW  = $clog2(c_NB + 1);
  localparam int c_DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int c_GAPW = $clog2(2 * CLKDIV);

  localparam logic [c_BCW-1:0]  c_BIT_FIRST = c_BCW'(c_NB - 1);
  localparam logic [c_DIVW-1:0] c_DIV_LAST  = c_DIVW'(CLKDIV - 1);
  // IDLE is entered one clk before the gap ends so a held valid is taken on time
  localparam logic [c_GAPW-1:0] c_GAP_LAST  = c_GAPW'(2 * CLKDIV - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic [c_NB-1:0]   r_shift,  w_shift_nxt;
  logic [c_BCW-1:0]  r_bitcnt, w_bitcnt_nxt;
  logic [c_DIVW-1:0] r_divcnt, w_divcnt_nxt;
  logic [c_GAPW-1:0] r_gapcnt, w_gapcnt_nxt;
  logic              r_sclk,   w_sclk_nxt;
  logic              r_cs_n,   w_cs_n_nxt;
  logic              r_sdo,    w_sdo_nxt;
  logic              r_done,   w_done_nxt;
  logic [c_NB-1:0]   w_frame;

  // Zero-extension to c_NB supplies the lead 0 bit when LEAD_ZERO=1
`ifdef ADC_WRITER_PARITY_EN
  assign w_frame = c_NB'({data, ^data});
`else
  assign w_frame = c_NB'(data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
      r_gapcnt <= '0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_sdo    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_divcnt <= w_divcnt_nxt;
      r_gapcnt <= w_gapcnt_nxt;
      r_sclk   <= w_sclk_nxt;
      r_cs_n   <= w_cs_n_nxt;
      r_sdo    <= w_sdo_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_divcnt_nxt = r_divcnt;
    w_gapcnt_nxt = r_gapcnt;
    w_sclk_nxt   = r_sclk;
    w_cs_n_nxt   = r_cs_n;
    w_sdo_nxt    = r_sdo;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid) begin
          w_state_nxt  = ST_SHIFT;
          w_shift_nxt  = w_frame << 1;
          w_sdo_nxt    = w_frame[c_NB-1];
          w_sclk_nxt   = 1'b1;
          w_cs_n_nxt   = 1'b0;
          w_bitcnt_nxt = c_BIT_FIRST;
          w_divcnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        if (r_divcnt != c_DIV_LAST) begin
          w_divcnt_nxt = r_divcnt + 1'b1;
        end else begin
          w_divcnt_nxt = '0;
          if (r_sclk) begin
            w_sclk_nxt = 1'b0;
          end else if (r_bitcnt == '0) begin
            w_state_nxt  = ST_GAP;
            w_cs_n_nxt   = 1'b1;
            w_sdo_nxt    = 1'b0;
            w_done_nxt   = 1'b1;
            w_gapcnt_nxt = '0;
          end else begin
            w_sclk_nxt   = 1'b1;
            w_sdo_nxt    = r_shift[c_NB-1];
            w_shift_nxt  = r_shift << 1;
            w_bitcnt_nxt = r_bitcnt - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_gapcnt == c_GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gapcnt_nxt = r_gapcnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ready = (r_state == ST_IDLE);
  assign sclk  = r_sclk;
  assign cs_n  = r_cs_n;
  assign sdo   = r_sdo;
  assign done  = r_done;

endmodule
`default_nettype wire
